axis_signed_divider: RTL and testbench

Iterative signed fixed-point divider that acts as the responder side of the divisor/dividend/dout stream interface used by our divider controllers. It accepts one divisor and one dividend per transaction on single-beat valid strobes. It computes a truncated signed quotient with DOUT_TDATA_WIDTH − DIVIDEND_TDATA_WIDTH fractional bits and returns it as a one-cycle dout valid pulse. It is a drop-in behavioural substitute for the vendor divider core in simulation and in low-throughput datapaths.

---
 rtl/axis_signed_divider.sv | 140 ++++++++++++++
 tb/tb_axis_signed_divider.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/axis_signed_divider.sv
// Iterative signed fixed-point divider (restoring, one quotient bit per cycle).
// Quotient is truncated toward zero, saturated, and returned as a single-cycle dout pulse.
module axis_signed_divider #(
    parameter int DOUT_TDATA_WIDTH     = 48,
    parameter int DIVISOR_TDATA_WIDTH  = 32,
    parameter int DIVIDEND_TDATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DIVISOR_TDATA_WIDTH-1:0]  s_axis_divisor_tdata,
    input  logic                            s_axis_divisor_tvalid,
    output logic                            s_axis_divisor_tready,
    input  logic [DIVIDEND_TDATA_WIDTH-1:0] s_axis_dividend_tdata,
    input  logic                            s_axis_dividend_tvalid,
    output logic                            s_axis_dividend_tready,
    output logic [DOUT_TDATA_WIDTH-1:0]     m_axis_dout_tdata,
    output logic                            m_axis_dout_tvalid,
    output logic                            divide_by_zero
);

    localparam int DW   = DOUT_TDATA_WIDTH;
    localparam int VW   = DIVISOR_TDATA_WIDTH;
    localparam int NW   = DIVIDEND_TDATA_WIDTH;
    localparam int FRAC = DW - NW;
    localparam int CW   = $clog2(DW);

    localparam logic [DW-1:0] SAT_POS = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SAT_NEG = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [DW-1:0] num_q;
    logic [DW-1:0] quo_q;
    logic [VW-1:0] den_q;
    logic [VW:0]   rem_q;
    logic [CW-1:0] cnt_q;
    logic          neg_q;
    logic          dvd_neg_q;
    logic          dz_q;
    logic          tready_q;

    logic          accept;
    logic [NW-1:0] dvd_abs;
    logic [VW-1:0] dvs_abs;
    logic [VW:0]   rem_shift;
    logic          rem_ge;
    logic [VW:0]   rem_next;
    logic [DW-1:0] result;

    assign accept = (state == IDLE) && s_axis_divisor_tvalid && s_axis_dividend_tvalid;

    assign s_axis_divisor_tready  = tready_q;
    assign s_axis_dividend_tready = tready_q;

    always_comb begin
        dvd_abs   = s_axis_dividend_tdata;
        dvs_abs   = s_axis_divisor_tdata;
        rem_shift = {rem_q[VW-1:0], num_q[DW-1]};
        rem_ge    = 1'b0;
        rem_next  = rem_shift;
        result    = quo_q;

        // Two's-complement negate in operand width keeps the most-negative magnitude exact as unsigned.
        if (s_axis_dividend_tdata[NW-1]) dvd_abs = ~s_axis_dividend_tdata + NW'(1);
        if (s_axis_divisor_tdata[VW-1])  dvs_abs = ~s_axis_divisor_tdata + VW'(1);

        if (rem_shift >= {1'b0, den_q}) begin
            rem_ge   = 1'b1;
            rem_next = rem_shift - {1'b0, den_q};
        end

        if (dz_q) begin
            result = dvd_neg_q ? SAT_NEG : SAT_POS;
        end else if (neg_q) begin
            result = (quo_q > SAT_NEG) ? SAT_NEG : (~quo_q + DW'(1));
        end else begin
            result = (quo_q > SAT_POS) ? SAT_POS : quo_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            num_q              <= '0;
            quo_q              <= '0;
            den_q              <= '0;
            rem_q              <= '0;
            cnt_q              <= '0;
            neg_q              <= 1'b0;
            dvd_neg_q          <= 1'b0;
            dz_q               <= 1'b0;
            tready_q           <= 1'b1;
            m_axis_dout_tdata  <= '0;
            m_axis_dout_tvalid <= 1'b0;
            divide_by_zero     <= 1'b0;
        end else begin
            // tready lags the state by one cycle so it rises together with tvalid falling.
            tready_q           <= (state == IDLE) && !accept;
            m_axis_dout_tvalid <= (state == DONE);
            divide_by_zero     <= (state == DONE) && dz_q;

            case (state)
                IDLE: begin
                    if (accept) begin
                        num_q     <= DW'(dvd_abs) << FRAC;
                        den_q     <= dvs_abs;
                        rem_q     <= '0;
                        quo_q     <= '0;
                        neg_q     <= s_axis_dividend_tdata[NW-1] ^ s_axis_divisor_tdata[VW-1];
                        dvd_neg_q <= s_axis_dividend_tdata[NW-1];
                        dz_q      <= (s_axis_divisor_tdata == '0);
                        cnt_q     <= CW'(DW - 1);
                        state     <= CALC;
                    end
                end
                CALC: begin
                    rem_q <= rem_next;
                    num_q <= num_q << 1;
                    quo_q <= {quo_q[DW-2:0], rem_ge};
                    if (cnt_q == '0) begin
                        state <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    m_axis_dout_tdata <= result;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_signed_divider.sv
// Directed bench for axis_signed_divider: hand-computed Q16 quotients, latency,
// saturation, divide-by-zero, busy/partial strobes and mid-operation reset.
module tb_axis_signed_divider;

    logic        clk;
    logic        rst_n;
    logic [31:0] divisor_tdata;
    logic        divisor_tvalid;
    logic        divisor_tready;
    logic [31:0] dividend_tdata;
    logic        dividend_tvalid;
    logic        dividend_tready;
    logic [47:0] dout_tdata;
    logic        dout_tvalid;
    logic        dbz;

    int checks   = 0;
    int failures = 0;

    axis_signed_divider dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .s_axis_divisor_tdata   (divisor_tdata),
        .s_axis_divisor_tvalid  (divisor_tvalid),
        .s_axis_divisor_tready  (divisor_tready),
        .s_axis_dividend_tdata  (dividend_tdata),
        .s_axis_dividend_tvalid (dividend_tvalid),
        .s_axis_dividend_tready (dividend_tready),
        .m_axis_dout_tdata      (dout_tdata),
        .m_axis_dout_tvalid     (dout_tvalid),
        .divide_by_zero         (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic [47:0] exp_dout);
        check({tag, "_tvalid"}, 64'(dout_tvalid), 64'd0);
        check({tag, "_dbz"}, 64'(dbz), 64'd0);
        check({tag, "_tready"}, 64'({divisor_tready, dividend_tready}), 64'd3);
        check({tag, "_dout"}, 64'(dout_tdata), 64'(exp_dout));
    endtask

    // One transaction; optionally re-strobes the valids 10 cycles into the operation.
    task automatic run_div(input string tag, input logic [31:0] dvd, input logic [31:0] dvs,
                           input logic [47:0] exp_q, input logic exp_dz, input bit poke);
        int cycles;
        bit seen;
        bit rdy_seen;
        @(negedge clk);
        dividend_tdata  = dvd;
        divisor_tdata   = dvs;
        dividend_tvalid = 1'b1;
        divisor_tvalid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dividend_tvalid = 1'b0;
        divisor_tvalid  = 1'b0;
        check({tag, "_rdy_fall"}, 64'({divisor_tready, dividend_tready}), 64'd0);
        cycles   = 0;
        seen     = 1'b0;
        rdy_seen = 1'b0;
        while (!seen && cycles < 200) begin
            if (dout_tvalid) begin
                seen = 1'b1;
            end else begin
                if (divisor_tready || dividend_tready) rdy_seen = 1'b1;
                if (poke && cycles == 10) begin
                    dividend_tdata  = 32'd1;
                    divisor_tdata   = 32'd1;
                    dividend_tvalid = 1'b1;
                    divisor_tvalid  = 1'b1;
                end else begin
                    dividend_tvalid = 1'b0;
                    divisor_tvalid  = 1'b0;
                end
                cycles++;
                @(negedge clk);
            end
        end
        dividend_tvalid = 1'b0;
        divisor_tvalid  = 1'b0;
        check({tag, "_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"}, 64'(cycles), 64'd49);
        check({tag, "_dout"}, 64'(dout_tdata), 64'(exp_q));
        check({tag, "_dbz"}, 64'(dbz), 64'(exp_dz));
        check({tag, "_rdy_busy"}, 64'(rdy_seen), 64'd0);
        check({tag, "_rdy_during_valid"}, 64'({divisor_tready, dividend_tready}), 64'd0);
        @(negedge clk);
        check_idle_outputs({tag, "_after"}, exp_q);
    endtask

    initial begin
        int pulses;
        rst_n           = 1'b0;
        divisor_tdata   = '0;
        dividend_tdata  = '0;
        divisor_tvalid  = 1'b0;
        dividend_tvalid = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset", 48'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset", 48'd0);

        run_div("p7_2",    32'd7,            32'd2,            48'd229376,        1'b0, 1'b0);
        run_div("n7_2",    -32'sd7,          32'd2,            -48'sd229376,      1'b0, 1'b0);
        run_div("p1_3",    32'd1,            32'd3,            48'd21845,         1'b0, 1'b0);
        run_div("n1_3",    -32'sd1,          32'd3,            -48'sd21845,       1'b0, 1'b0);
        run_div("p1_n3",   32'd1,            -32'sd3,          -48'sd21845,       1'b0, 1'b0);
        run_div("big",     32'd1000000,      -32'sd333,        -48'sd196804804,   1'b0, 1'b0);
        run_div("p5_0",    32'd5,            32'd0,            48'h7FFF_FFFF_FFFF, 1'b1, 1'b0);
        run_div("n5_0",    -32'sd5,          32'd0,            48'h8000_0000_0000, 1'b1, 1'b0);
        run_div("min_n1",  32'h8000_0000,    32'hFFFF_FFFF,    48'h7FFF_FFFF_FFFF, 1'b0, 1'b0);
        run_div("min_p1",  32'h8000_0000,    32'd1,            48'h8000_0000_0000, 1'b0, 1'b0);
        run_div("z_n9",    32'd0,            -32'sd9,          48'd0,             1'b0, 1'b0);
        run_div("busy",    32'd100,          32'd7,            48'd936228,        1'b0, 1'b1);

        // Divisor strobe alone must not start anything.
        @(negedge clk);
        divisor_tdata  = 32'd3;
        divisor_tvalid = 1'b1;
        @(negedge clk);
        divisor_tvalid = 1'b0;
        pulses = 0;
        repeat (60) begin
            @(negedge clk);
            if (dout_tvalid) pulses++;
        end
        check("partial_pulses", 64'(pulses), 64'd0);
        check_idle_outputs("partial", 48'd936228);

        // Reset 20 cycles into CALC aborts the operation.
        @(negedge clk);
        dividend_tdata  = 32'd11;
        divisor_tdata   = 32'd4;
        dividend_tvalid = 1'b1;
        divisor_tvalid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dividend_tvalid = 1'b0;
        divisor_tvalid  = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset", 48'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (60) begin
            @(negedge clk);
            if (dout_tvalid) pulses++;
        end
        check("aborted_pulses", 64'(pulses), 64'd0);
        check_idle_outputs("after_abort", 48'd0);

        run_div("p9_3",    32'd9,            32'd3,            48'd196608,        1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
